lsu_axi_lane: RTL and testbench

- Parametrised load/store unit between EXU and WBU. Drives one AXI4 master port with single-beat transactions.
- Generalises the previous LSU with:
  - configurable data width;
  - byte-lane alignment of write data and strobes, and of read data;
  - independent AW/W handshakes;
  - misalignment and illegal-op detection;
  - AXI error and ID reporting to the pipeline.
- Handles one access at a time; no outstanding overlap.

---
 rtl/lsu_axi_lane.sv | 237 +++++++++++++++++++++++
 tb/tb_lsu_axi_lane.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_axi_lane.sv
// Load/store unit between EXU and WBU driving single-beat AXI4 transactions.
// Aligns store data/strobes to the byte lane and extracts/extends load data.
module lsu_axi_lane #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned ID_W   = 4,
    parameter int unsigned AXI_ID = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          in_rw,
    input  logic [1:0]          in_size,
    input  logic                in_signed,
    input  logic [ADDR_W-1:0]   in_addr,
    input  logic [DATA_W-1:0]   in_wdata,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_rdata,
    output logic [1:0]          out_fault,
    output logic [ADDR_W-1:0]   araddr,
    output logic                arvalid,
    input  logic                arready,
    output logic [ID_W-1:0]     arid,
    output logic [7:0]          arlen,
    output logic [2:0]          arsize,
    output logic [1:0]          arburst,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    input  logic                rvalid,
    output logic                rready,
    input  logic                rlast,
    input  logic [ID_W-1:0]     rid,
    output logic [ADDR_W-1:0]   awaddr,
    output logic                awvalid,
    input  logic                awready,
    output logic [ID_W-1:0]     awid,
    output logic [7:0]          awlen,
    output logic [2:0]          awsize,
    output logic [1:0]          awburst,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wvalid,
    input  logic                wready,
    output logic                wlast,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready,
    input  logic [ID_W-1:0]     bid
);
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned OFF_W  = $clog2(STRB_W);

    typedef enum logic [2:0] {StIdle, StAr, StR, StAwW, StB, StDone} state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [1:0]          size_q;
    logic                signed_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic                arvalid_q, awvalid_q, wvalid_q, rready_q, bready_q, out_valid_q;
    logic [DATA_W-1:0]   out_rdata_q;
    logic [1:0]          fault_q;

    logic [OFF_W-1:0]    in_off;
    logic [2:0]          align_mask;
    logic                misaligned, size_bad;
    logic [STRB_W-1:0]   strb_base, acc_strb;
    logic [DATA_W-1:0]   acc_wdata;
    logic [DATA_W-1:0]   rshift, load_mask, load_val;
    logic                sbit;
    logic                r_err, b_err;
    logic                aw_pend_d, w_pend_d;

    assign in_off     = in_addr[OFF_W-1:0];
    assign misaligned = |(in_addr[2:0] & align_mask);
    assign size_bad   = (in_size == 2'd3) && (DATA_W == 32);
    assign acc_wdata  = in_wdata << {in_off, 3'b000};
    assign acc_strb   = strb_base << in_off;

    always_comb begin
        align_mask = 3'b000;
        unique case (in_size)
            2'd0: align_mask = 3'b000;
            2'd1: align_mask = 3'b001;
            2'd2: align_mask = 3'b011;
            2'd3: align_mask = 3'b111;
            default: align_mask = 3'b000;
        endcase
        strb_base = '0;
        for (int unsigned i = 0; i < STRB_W; i++) begin
            strb_base[i] = (i < (32'd1 << in_size));
        end
    end

    // Load path: bring the addressed lane down to bit 0, then trim and extend.
    always_comb begin
        rshift = rdata >> {addr_q[OFF_W-1:0], 3'b000};
        load_mask = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            load_mask[i] = (i < (32'd8 << size_q));
        end
        sbit = 1'b0;
        unique case (size_q)
            2'd0: sbit = rshift[7];
            2'd1: sbit = rshift[15];
            2'd2: sbit = rshift[31];
            2'd3: sbit = rshift[DATA_W-1];
            default: sbit = 1'b0;
        endcase
        load_val = (rshift & load_mask) | ({DATA_W{signed_q & sbit}} & ~load_mask);
    end

    assign r_err     = (rresp != 2'b00) || (rid != ID_W'(AXI_ID)) || !rlast;
    assign b_err     = (bresp != 2'b00) || (bid != ID_W'(AXI_ID));
    assign aw_pend_d = awvalid_q & ~awready;
    assign w_pend_d  = wvalid_q & ~wready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            size_q      <= 2'd0;
            signed_q    <= 1'b0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            arvalid_q   <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            rready_q    <= 1'b0;
            bready_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_rdata_q <= '0;
            fault_q     <= 2'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        addr_q      <= in_addr;
                        size_q      <= in_size;
                        signed_q    <= in_signed;
                        wdata_q     <= acc_wdata;
                        wstrb_q     <= acc_strb;
                        out_rdata_q <= '0;
                        fault_q     <= 2'd0;
                        if (in_rw == 2'b11 || size_bad) begin
                            fault_q     <= 2'd3;
                            out_valid_q <= 1'b1;
                            state_q     <= StDone;
                        end else if (misaligned) begin
                            fault_q     <= 2'd1;
                            out_valid_q <= 1'b1;
                            state_q     <= StDone;
                        end else if (in_rw == 2'b00) begin
                            out_valid_q <= 1'b1;
                            state_q     <= StDone;
                        end else if (in_rw == 2'b10) begin
                            arvalid_q <= 1'b1;
                            state_q   <= StAr;
                        end else begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= StAwW;
                        end
                    end
                end
                StAr: begin
                    if (arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= StR;
                    end
                end
                StR: begin
                    if (rvalid) begin
                        rready_q    <= 1'b0;
                        out_valid_q <= 1'b1;
                        fault_q     <= r_err ? 2'd2 : 2'd0;
                        out_rdata_q <= r_err ? '0 : load_val;
                        state_q     <= StDone;
                    end
                end
                StAwW: begin
                    // AW and W retire independently; B waits for both.
                    awvalid_q <= aw_pend_d;
                    wvalid_q  <= w_pend_d;
                    if (!aw_pend_d && !w_pend_d) begin
                        bready_q <= 1'b1;
                        state_q  <= StB;
                    end
                end
                StB: begin
                    if (bvalid) begin
                        bready_q    <= 1'b0;
                        out_valid_q <= 1'b1;
                        fault_q     <= b_err ? 2'd2 : 2'd0;
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = out_valid_q;
    assign out_rdata = out_rdata_q;
    assign out_fault = fault_q;

    assign araddr  = addr_q;
    assign arvalid = arvalid_q;
    assign arid    = ID_W'(AXI_ID);
    assign arlen   = 8'd0;
    assign arsize  = {1'b0, size_q};
    assign arburst = 2'b01;
    assign rready  = rready_q;

    assign awaddr  = addr_q;
    assign awvalid = awvalid_q;
    assign awid    = ID_W'(AXI_ID);
    assign awlen   = 8'd0;
    assign awsize  = {1'b0, size_q};
    assign awburst = 2'b01;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;
    assign wvalid  = wvalid_q;
    assign wlast   = 1'b1;
    assign bready  = bready_q;
endmodule

// File: tb/tb_lsu_axi_lane.sv
// Directed bench for lsu_axi_lane: a 32-bit and a 64-bit instance share one
// reactive AXI slave; results are scored against an expectation queue.
module tb_lsu_axi_lane;
    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        in_valid;
    logic [1:0]  in_rw, in_size;
    logic        in_signed;
    logic [31:0] in_addr;
    logic [63:0] in_wdata;
    logic        out_ready;
    logic        arready, rvalid, rlast, awready, wready, bvalid;
    logic [63:0] rdata;
    logic [1:0]  rresp, bresp;
    logic [3:0]  rid, bid;

    logic        a_in_ready, a_out_valid, a_arvalid, a_rready, a_awvalid, a_wvalid, a_wlast;
    logic        a_bready;
    logic [31:0] a_out_rdata, a_araddr, a_awaddr, a_wdata;
    logic [1:0]  a_out_fault, a_arburst, a_awburst;
    logic [3:0]  a_arid, a_awid, a_wstrb;
    logic [7:0]  a_arlen, a_awlen;
    logic [2:0]  a_arsize, a_awsize;

    logic        b_in_ready, b_out_valid, b_arvalid, b_rready, b_awvalid, b_wvalid, b_wlast;
    logic        b_bready;
    logic [63:0] b_out_rdata, b_wdata;
    logic [31:0] b_araddr, b_awaddr;
    logic [1:0]  b_out_fault, b_arburst, b_awburst;
    logic [3:0]  b_arid, b_awid;
    logic [7:0]  b_wstrb, b_arlen, b_awlen;
    logic [2:0]  b_arsize, b_awsize;

    logic        cur_in_ready, cur_out_valid, cur_arvalid, cur_rready, cur_awvalid;
    logic        cur_wvalid, cur_bready;
    logic [63:0] cur_out_rdata, cur_wdata;
    logic [31:0] cur_araddr, cur_awaddr;
    logic [1:0]  cur_out_fault;
    logic [2:0]  cur_arsize, cur_awsize;
    logic [7:0]  cur_wstrb;

    typedef struct {
        logic [63:0] rd;
        logic [1:0]  f;
        int          lat;
    } exp_t;
    exp_t sb[$];

    int vectors = 0;
    int miscompares = 0;
    int ar_n, aw_n, w_n, b_n, bad_order, s_aw_dly;

    always #5 clk = ~clk;

    lsu_axi_lane #(.DATA_W(32), .ADDR_W(32), .ID_W(4), .AXI_ID(2)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid & ~sel), .in_ready(a_in_ready),
        .in_rw(in_rw), .in_size(in_size), .in_signed(in_signed), .in_addr(in_addr),
        .in_wdata(in_wdata[31:0]), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_rdata(a_out_rdata), .out_fault(a_out_fault),
        .araddr(a_araddr), .arvalid(a_arvalid), .arready(arready), .arid(a_arid),
        .arlen(a_arlen), .arsize(a_arsize), .arburst(a_arburst),
        .rdata(rdata[31:0]), .rresp(rresp), .rvalid(rvalid), .rready(a_rready),
        .rlast(rlast), .rid(rid),
        .awaddr(a_awaddr), .awvalid(a_awvalid), .awready(awready), .awid(a_awid),
        .awlen(a_awlen), .awsize(a_awsize), .awburst(a_awburst),
        .wdata(a_wdata), .wstrb(a_wstrb), .wvalid(a_wvalid), .wready(wready), .wlast(a_wlast),
        .bresp(bresp), .bvalid(bvalid), .bready(a_bready), .bid(bid)
    );

    lsu_axi_lane #(.DATA_W(64), .ADDR_W(32), .ID_W(4), .AXI_ID(2)) u_dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid & sel), .in_ready(b_in_ready),
        .in_rw(in_rw), .in_size(in_size), .in_signed(in_signed), .in_addr(in_addr),
        .in_wdata(in_wdata), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_rdata(b_out_rdata), .out_fault(b_out_fault),
        .araddr(b_araddr), .arvalid(b_arvalid), .arready(arready), .arid(b_arid),
        .arlen(b_arlen), .arsize(b_arsize), .arburst(b_arburst),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(b_rready),
        .rlast(rlast), .rid(rid),
        .awaddr(b_awaddr), .awvalid(b_awvalid), .awready(awready), .awid(b_awid),
        .awlen(b_awlen), .awsize(b_awsize), .awburst(b_awburst),
        .wdata(b_wdata), .wstrb(b_wstrb), .wvalid(b_wvalid), .wready(wready), .wlast(b_wlast),
        .bresp(bresp), .bvalid(bvalid), .bready(b_bready), .bid(bid)
    );

    always_comb begin
        if (sel) begin
            cur_in_ready  = b_in_ready;   cur_out_valid = b_out_valid;
            cur_arvalid   = b_arvalid;    cur_rready    = b_rready;
            cur_awvalid   = b_awvalid;    cur_wvalid    = b_wvalid;
            cur_bready    = b_bready;     cur_out_rdata = b_out_rdata;
            cur_wdata     = b_wdata;      cur_araddr    = b_araddr;
            cur_awaddr    = b_awaddr;     cur_out_fault = b_out_fault;
            cur_arsize    = b_arsize;     cur_awsize    = b_awsize;
            cur_wstrb     = b_wstrb;
        end else begin
            cur_in_ready  = a_in_ready;   cur_out_valid = a_out_valid;
            cur_arvalid   = a_arvalid;    cur_rready    = a_rready;
            cur_awvalid   = a_awvalid;    cur_wvalid    = a_wvalid;
            cur_bready    = a_bready;     cur_out_rdata = {32'h0, a_out_rdata};
            cur_wdata     = {32'h0, a_wdata};
            cur_araddr    = a_araddr;     cur_awaddr    = a_awaddr;
            cur_out_fault = a_out_fault;  cur_arsize    = a_arsize;
            cur_awsize    = a_awsize;     cur_wstrb     = {4'h0, a_wstrb};
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One request through the selected instance with a zero-wait slave
    // (AW may be held off for s_aw_dly cycles).
    task automatic txn(input logic s, input logic [1:0] rw, input logic [1:0] size,
                       input logic sgn, input logic [31:0] addr, input logic [63:0] wd,
                       input logic [63:0] exp_rd, input logic [1:0] exp_f, input int exp_lat,
                       input logic [63:0] exp_wd, input logic [7:0] exp_ws);
        exp_t e;
        int   lat;
        sel = s; in_rw = rw; in_size = size; in_signed = sgn; in_addr = addr; in_wdata = wd;
        #0;
        check("in_ready_before", {63'h0, cur_in_ready}, 64'h1);
        in_valid = 1'b1;
        sb.push_back('{rd: exp_rd, f: exp_f, lat: exp_lat});
        step();
        in_valid = 1'b0;
        lat = 1; ar_n = 0; aw_n = 0; w_n = 0; b_n = 0; bad_order = 0;
        while (!cur_out_valid && lat < 40) begin
            arready = cur_arvalid;
            if (cur_arvalid) begin
                ar_n++;
                check("araddr", {32'h0, cur_araddr}, {32'h0, addr});
                check("arsize", {61'h0, cur_arsize}, {62'h0, size});
            end
            rvalid = cur_rready;
            if (cur_awvalid) aw_n++;
            awready = cur_awvalid && (aw_n >= s_aw_dly);
            if (awready) begin
                check("awaddr", {32'h0, cur_awaddr}, {32'h0, addr});
                check("awsize", {61'h0, cur_awsize}, {62'h0, size});
            end
            wready = cur_wvalid;
            if (cur_wvalid) begin
                w_n++;
                check("wdata", cur_wdata, exp_wd);
                check("wstrb", {56'h0, cur_wstrb}, {56'h0, exp_ws});
            end
            bvalid = cur_bready;
            if (cur_bready) begin
                b_n++;
                if (cur_awvalid || cur_wvalid) bad_order++;
            end
            step();
            lat++;
        end
        arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        check("out_valid", {63'h0, cur_out_valid}, 64'h1);
        check("in_ready_busy", {63'h0, cur_in_ready}, 64'h0);
        e = sb.pop_front();
        check("out_rdata", cur_out_rdata, e.rd);
        check("out_fault", {62'h0, cur_out_fault}, {62'h0, e.f});
        check("latency", 64'(lat), 64'(e.lat));
        step();
        check("out_valid_drop", {63'h0, cur_out_valid}, 64'h0);
        check("in_ready_after", {63'h0, cur_in_ready}, 64'h1);
    endtask

    initial begin
        rst = 1'b1; sel = 1'b0; in_valid = 1'b0; in_rw = 2'b00; in_size = 2'd0;
        in_signed = 1'b0; in_addr = '0; in_wdata = '0; out_ready = 1'b1;
        arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        rdata = '0; rresp = 2'b00; bresp = 2'b00; rid = 4'd2; bid = 4'd2; rlast = 1'b1;
        s_aw_dly = 1;
        repeat (3) step();
        rst = 1'b0;
        step();

        check("rst_in_ready", {63'h0, a_in_ready}, 64'h1);
        check("rst_valids", {58'h0, a_arvalid, a_awvalid, a_wvalid, a_rready, a_bready,
                             a_out_valid}, 64'h0);
        check("rst_out", {30'h0, a_out_fault, a_out_rdata}, 64'h0);
        check("rst_valids64", {58'h0, b_arvalid, b_awvalid, b_wvalid, b_rready, b_bready,
                               b_out_valid}, 64'h0);
        check("const_ar", {42'h0, a_arid, a_arlen, a_arburst, b_arid, b_arlen},
              {42'h0, 4'd2, 8'd0, 2'b01, 4'd2, 8'd0});
        check("const_aw", {48'h0, a_awid, a_awlen, a_awburst, a_wlast, b_wlast},
              {48'h0, 4'd2, 8'd0, 2'b01, 1'b1, 1'b1});

        // Loads on the 32-bit lane
        rdata = 64'h0000_0000_8012_3456;
        txn(1'b0, 2'b10, 2'd0, 1'b1, 32'h1003, 64'h0, 64'hFFFF_FF80, 2'd0, 3, 64'h0, 8'h0);
        rdata = 64'h0000_0000_BEEF_1234;
        txn(1'b0, 2'b10, 2'd1, 1'b1, 32'h1002, 64'h0, 64'hFFFF_BEEF, 2'd0, 3, 64'h0, 8'h0);
        rdata = 64'h0000_0000_0000_C300;
        txn(1'b0, 2'b10, 2'd0, 1'b0, 32'h1001, 64'h0, 64'h0000_00C3, 2'd0, 3, 64'h0, 8'h0);
        rdata = 64'h0000_0000_DEAD_BEEF;
        txn(1'b0, 2'b10, 2'd2, 1'b1, 32'h1004, 64'h0, 64'hDEAD_BEEF, 2'd0, 3, 64'h0, 8'h0);

        // Stores on the 32-bit lane
        txn(1'b0, 2'b01, 2'd2, 1'b0, 32'h2000, 64'h1234_5678, 64'h0, 2'd0, 3,
            64'h1234_5678, 8'h0F);
        check("b_once", 64'(b_n), 64'd1);
        txn(1'b0, 2'b01, 2'd0, 1'b0, 32'h2001, 64'h0000_00AB, 64'h0, 2'd0, 3,
            64'h0000_AB00, 8'h02);
        txn(1'b0, 2'b01, 2'd1, 1'b0, 32'h2002, 64'h0000_1234, 64'h0, 2'd0, 3,
            64'h1234_0000, 8'h0C);

        // AW stalled, W immediate
        s_aw_dly = 3;
        txn(1'b0, 2'b01, 2'd2, 1'b0, 32'h2004, 64'h55AA_55AA, 64'h0, 2'd0, 5,
            64'h55AA_55AA, 8'h0F);
        s_aw_dly = 1;
        check("aw_cycles", 64'(aw_n), 64'd3);
        check("w_cycles", 64'(w_n), 64'd1);
        check("b_after_aw", 64'(bad_order), 64'd0);
        check("b_handshakes", 64'(b_n), 64'd1);

        // Faults and pass-through: no bus traffic
        txn(1'b0, 2'b10, 2'd2, 1'b0, 32'h1002, 64'h0, 64'h0, 2'd1, 1, 64'h0, 8'h0);
        check("misalign_no_ar", 64'(ar_n), 64'd0);
        txn(1'b0, 2'b11, 2'd2, 1'b0, 32'h1000, 64'h0, 64'h0, 2'd3, 1, 64'h0, 8'h0);
        txn(1'b0, 2'b10, 2'd3, 1'b0, 32'h1000, 64'h0, 64'h0, 2'd3, 1, 64'h0, 8'h0);
        txn(1'b0, 2'b00, 2'd2, 1'b0, 32'h3000, 64'h0, 64'h0, 2'd0, 1, 64'h0, 8'h0);
        check("pass_no_traffic", 64'(ar_n + aw_n + w_n), 64'd0);

        // Bus errors
        rdata = 64'h0000_0000_1234_5678; rresp = 2'b10;
        txn(1'b0, 2'b10, 2'd2, 1'b0, 32'h1000, 64'h0, 64'h0, 2'd2, 3, 64'h0, 8'h0);
        rresp = 2'b00; rlast = 1'b0;
        txn(1'b0, 2'b10, 2'd2, 1'b0, 32'h1000, 64'h0, 64'h0, 2'd2, 3, 64'h0, 8'h0);
        rlast = 1'b1; rid = 4'd7;
        txn(1'b0, 2'b10, 2'd2, 1'b0, 32'h1000, 64'h0, 64'h0, 2'd2, 3, 64'h0, 8'h0);
        rid = 4'd2; bid = 4'd5;
        txn(1'b0, 2'b01, 2'd2, 1'b0, 32'h2000, 64'hCAFE_0001, 64'h0, 2'd2, 3,
            64'hCAFE_0001, 8'h0F);
        bid = 4'd2;

        // Reset while AR is waiting for arready
        sel = 1'b0; in_rw = 2'b10; in_size = 2'd2; in_signed = 1'b0; in_addr = 32'h1000;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("ar_pending", {63'h0, a_arvalid}, 64'h1);
        step();
        check("ar_held", {32'h0, a_araddr}, 64'h1000);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid_ar", {61'h0, a_arvalid, a_in_ready, a_out_valid}, 64'b010);
        rdata = 64'h0000_0000_CAFE_F00D;
        txn(1'b0, 2'b10, 2'd2, 1'b0, 32'h1008, 64'h0, 64'hCAFE_F00D, 2'd0, 3, 64'h0, 8'h0);

        // 64-bit lane
        txn(1'b1, 2'b01, 2'd1, 1'b0, 32'h2006, 64'hBEEF, 64'h0, 2'd0, 3,
            64'hBEEF_0000_0000_0000, 8'hC0);
        rdata = 64'h8000_0000_0000_0000;
        txn(1'b1, 2'b10, 2'd2, 1'b1, 32'h2004, 64'h0, 64'hFFFF_FFFF_8000_0000, 2'd0, 3,
            64'h0, 8'h0);
        rdata = 64'h0123_4567_89AB_CDEF;
        txn(1'b1, 2'b10, 2'd3, 1'b0, 32'h2008, 64'h0, 64'h0123_4567_89AB_CDEF, 2'd0, 3,
            64'h0, 8'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
